sdpram16_arbiter: RTL and testbench

//  Shares one sdpram16 (16-bit simple dual-port RAM, byte enables, 2-cycle pipelined read) among NUM_CLIENTS requesters.

---
 rtl/sdpram16_arb_pkg.sv | 22 ++
 rtl/sdpram16_rr_pick.sv | 54 +++++
 rtl/sdpram16_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_sdpram16_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdpram16_arb_pkg.sv
// ----------------------------------------------------------------------------
// sdpram16_arb_pkg
//   Shared types and constants for the sdpram16 access arbiter.
//   RD_LATENCY  : read pipeline depth of the sdpram16 instance (cycles from
//                 read_enable being sampled to read_data being valid).
//   MAX_CLIENTS : largest supported requester count.
//   client_id_t : encoded client index.
//   rd_track_t  : one stage of the in-flight read tracker (valid + owner id).
// ----------------------------------------------------------------------------
package sdpram16_arb_pkg;

  localparam int RD_LATENCY  = 2;
  localparam int MAX_CLIENTS = 8;

  typedef logic [2:0] client_id_t;

  typedef struct packed {
    logic       valid;
    client_id_t id;
  } rd_track_t;

endpackage

// File: rtl/sdpram16_rr_pick.sv
// ----------------------------------------------------------------------------
// sdpram16_rr_pick
//   Combinational rotate-priority picker. The search for a requester starts
//   at ptr_i and wraps modulo NUM_CLIENTS; the first requester found wins.
//   Ports:
//     req_i  in  NUM_CLIENTS  request vector
//     ptr_i  in  3            search start index, must be < NUM_CLIENTS
//     gnt_o  out NUM_CLIENTS  one-hot grant (all zero when no request)
//     id_o   out 3            index of the granted client (0 when none)
//     any_o  out 1            a grant was made
// ----------------------------------------------------------------------------
module sdpram16_rr_pick
  import sdpram16_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4
) (
  input  logic [NUM_CLIENTS-1:0] req_i,
  input  client_id_t             ptr_i,
  output logic [NUM_CLIENTS-1:0] gnt_o,
  output client_id_t             id_o,
  output logic                   any_o
);

  logic [2*NUM_CLIENTS-1:0] req_dbl;
  logic [NUM_CLIENTS-1:0]   req_rot;
  logic [3:0]               id_sum;

  // Doubling the request vector and shifting by ptr_i rotates it so that
  // bit k of req_rot is client (ptr_i + k) mod NUM_CLIENTS.
  // NOTE: every signal driven here gets a default at the top of the block,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    req_dbl = {req_i, req_i} >> ptr_i;
    req_rot = req_dbl[NUM_CLIENTS-1:0];
    any_o   = 1'b0;
    id_o    = '0;
    id_sum  = '0;
    gnt_o   = '0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (!any_o && req_rot[k]) begin
        any_o  = 1'b1;
        id_sum = {1'b0, ptr_i} + 4'(k);
        if (id_sum >= 4'(NUM_CLIENTS)) begin
          id_sum = id_sum - 4'(NUM_CLIENTS);
        end
        id_o = id_sum[2:0];
      end
    end
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      gnt_o[i] = any_o && (id_o == client_id_t'(i));
    end
  end

endmodule

// File: rtl/sdpram16_arbiter.sv
// ----------------------------------------------------------------------------
// sdpram16_arbiter
//   Shares one sdpram16 (16-bit simple dual-port RAM, byte enables, 2-cycle
//   pipelined read) among NUM_CLIENTS requesters. At most one operation is
//   accepted per cycle; it is driven on the registered mem_* ports in the
//   following cycle. Reads are tracked through the RAM pipeline and returned
//   with a one-cycle cl_rvalid_o strobe to the issuing client three cycles
//   after acceptance.
//
//   Configuration macro: SDPRAM16_ARB_FIXED_PRIO_EN
//     defined   : client 0 wins whenever it requests; clients 1..N-1 share
//                 the round-robin pointer, which client-0 grants leave alone.
//     undefined : plain round-robin over all clients.
//
//   Ports:
//     clk, rst_n            clock, asynchronous active-low reset
//     cl_req_i   [N]        per-client request, held until granted
//     cl_we_i    [N]        1 = write, 0 = read
//     cl_addr_i  [N*AW]     client i address at [i*AW +: AW]
//     cl_wdata_i [N*16]     client i write data at [i*16 +: 16]
//     cl_be_i    [N*2]      client i byte enables at [i*2 +: 2], [0] = low byte
//     cl_gnt_o   [N]        one-hot accept (combinational)
//     cl_rvalid_o[N]        read-return strobe
//     cl_rdata_o [16]       read data, valid with any cl_rvalid_o bit
//     mem_*_o               registered RAM write/read port controls
//     mem_read_data_i [16]  RAM read data
// ----------------------------------------------------------------------------
module sdpram16_arbiter
  import sdpram16_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int ADDR_WIDTH  = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CLIENTS-1:0]          cl_req_i,
  input  logic [NUM_CLIENTS-1:0]          cl_we_i,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] cl_addr_i,
  input  logic [NUM_CLIENTS*16-1:0]       cl_wdata_i,
  input  logic [NUM_CLIENTS*2-1:0]        cl_be_i,
  output logic [NUM_CLIENTS-1:0]          cl_gnt_o,
  output logic [NUM_CLIENTS-1:0]          cl_rvalid_o,
  output logic [15:0]                     cl_rdata_o,
  output logic [ADDR_WIDTH-1:0]           mem_write_addr_o,
  output logic [15:0]                     mem_write_data_o,
  output logic                            mem_write_enable_o,
  output logic [1:0]                      mem_byte_enable_o,
  output logic [ADDR_WIDTH-1:0]           mem_read_addr_o,
  output logic                            mem_read_enable_o,
  input  logic [15:0]                     mem_read_data_i
);

  localparam client_id_t LAST_ID = client_id_t'(NUM_CLIENTS - 1);
`ifdef SDPRAM16_ARB_FIXED_PRIO_EN
  // Client 0 is outside the rotation, so the pointer wraps to 1.
  localparam client_id_t PTR_WRAP = client_id_t'(1);
`else
  localparam client_id_t PTR_WRAP = '0;
`endif

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  client_id_t             rr_ptr_q, rr_ptr_d;
  logic [NUM_CLIENTS-1:0] rr_req;
  logic [NUM_CLIENTS-1:0] pick_gnt;
  client_id_t             pick_id;
  logic                   pick_any;
  logic [NUM_CLIENTS-1:0] gnt;

  always_comb begin
    rr_req = cl_req_i;
`ifdef SDPRAM16_ARB_FIXED_PRIO_EN
    rr_req[0] = 1'b0;
`endif
  end

  sdpram16_rr_pick #(
    .NUM_CLIENTS(NUM_CLIENTS)
  ) u_pick (
    .req_i(rr_req),
    .ptr_i(rr_ptr_q),
    .gnt_o(pick_gnt),
    .id_o (pick_id),
    .any_o(pick_any)
  );

  always_comb begin
    gnt      = pick_gnt;
    rr_ptr_d = rr_ptr_q;
`ifdef SDPRAM16_ARB_FIXED_PRIO_EN
    if (cl_req_i[0]) begin
      gnt    = '0;
      gnt[0] = 1'b1;
    end else if (pick_any) begin
      rr_ptr_d = (pick_id == LAST_ID) ? PTR_WRAP : pick_id + 3'd1;
    end
`else
    if (pick_any) begin
      rr_ptr_d = (pick_id == LAST_ID) ? PTR_WRAP : pick_id + 3'd1;
    end
`endif
  end

  // No client may see an accept while the issue registers are held in reset.
  assign cl_gnt_o = gnt & {NUM_CLIENTS{rst_n}};

  // --------------------------------------------------------------------------
  // Issue: mux the granted client's request onto the RAM port registers
  // --------------------------------------------------------------------------
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [15:0]           sel_wdata;
  logic [1:0]            sel_be;
  client_id_t            sel_id;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    sel_id    = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (gnt[i]) begin
        sel_we    = cl_we_i[i];
        sel_addr  = cl_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = cl_wdata_i[i*16 +: 16];
        sel_be    = cl_be_i[i*2 +: 2];
        sel_id    = client_id_t'(i);
      end
    end
  end

  logic [ADDR_WIDTH-1:0] mem_write_addr_q,   mem_write_addr_d;
  logic [15:0]           mem_write_data_q,   mem_write_data_d;
  logic                  mem_write_enable_q, mem_write_enable_d;
  logic [1:0]            mem_byte_enable_q,  mem_byte_enable_d;
  logic [ADDR_WIDTH-1:0] mem_read_addr_q,    mem_read_addr_d;
  logic                  mem_read_enable_q,  mem_read_enable_d;
  client_id_t            rd_id_q,            rd_id_d;

  // Enables are single-cycle strobes; address/data/be hold when idle.
  always_comb begin
    mem_write_addr_d   = mem_write_addr_q;
    mem_write_data_d   = mem_write_data_q;
    mem_byte_enable_d  = mem_byte_enable_q;
    mem_read_addr_d    = mem_read_addr_q;
    rd_id_d            = rd_id_q;
    mem_write_enable_d = 1'b0;
    mem_read_enable_d  = 1'b0;
    if (|gnt) begin
      if (sel_we) begin
        mem_write_enable_d = 1'b1;
        mem_write_addr_d   = sel_addr;
        mem_write_data_d   = sel_wdata;
        mem_byte_enable_d  = sel_be;
      end else begin
        mem_read_enable_d  = 1'b1;
        mem_read_addr_d    = sel_addr;
        rd_id_d            = sel_id;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read tracking: the issue register plus RD_LATENCY stages line up with
  // the RAM pipeline, so the last stage coincides with valid read data.
  // --------------------------------------------------------------------------
  rd_track_t rd_pipe_q [RD_LATENCY];
  rd_track_t rd_pipe_d [RD_LATENCY];

  always_comb begin
    rd_pipe_d[0].valid = mem_read_enable_q;
    rd_pipe_d[0].id    = rd_id_q;
    for (int k = 1; k < RD_LATENCY; k++) begin
      rd_pipe_d[k] = rd_pipe_q[k-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, whatever order the simulator runs
  // the blocks in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q           <= '0;
      mem_write_addr_q   <= '0;
      mem_write_data_q   <= '0;
      mem_write_enable_q <= 1'b0;
      mem_byte_enable_q  <= '0;
      mem_read_addr_q    <= '0;
      mem_read_enable_q  <= 1'b0;
      rd_id_q            <= '0;
      // NOTE: the tracker is a small shift register, not a RAM, so it is
      // cleared on reset; clearing the valids is what drops in-flight reads.
      for (int k = 0; k < RD_LATENCY; k++) begin
        rd_pipe_q[k] <= '0;
      end
    end else begin
      rr_ptr_q           <= rr_ptr_d;
      mem_write_addr_q   <= mem_write_addr_d;
      mem_write_data_q   <= mem_write_data_d;
      mem_write_enable_q <= mem_write_enable_d;
      mem_byte_enable_q  <= mem_byte_enable_d;
      mem_read_addr_q    <= mem_read_addr_d;
      mem_read_enable_q  <= mem_read_enable_d;
      rd_id_q            <= rd_id_d;
      for (int k = 0; k < RD_LATENCY; k++) begin
        rd_pipe_q[k] <= rd_pipe_d[k];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    cl_rvalid_o = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cl_rvalid_o[i] = rd_pipe_q[RD_LATENCY-1].valid &&
                       (rd_pipe_q[RD_LATENCY-1].id == client_id_t'(i));
    end
  end

  assign cl_rdata_o         = mem_read_data_i;
  assign mem_write_addr_o   = mem_write_addr_q;
  assign mem_write_data_o   = mem_write_data_q;
  assign mem_write_enable_o = mem_write_enable_q;
  assign mem_byte_enable_o  = mem_byte_enable_q;
  assign mem_read_addr_o    = mem_read_addr_q;
  assign mem_read_enable_o  = mem_read_enable_q;

endmodule

// File: tb/tb_sdpram16_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sdpram16_arbiter
//   Self-checking bench for sdpram16_arbiter with 4 clients and a behavioural
//   sdpram16 model (byte-enabled write, 2-cycle pipelined read). Inputs are
//   driven 1 ns after posedge, outputs sampled 4 ns after posedge.
//   Works in both builds; SDPRAM16_ARB_FIXED_PRIO_EN selects the expected
//   grant order of the full-load sequence.
// ----------------------------------------------------------------------------
module tb_sdpram16_arbiter;

  localparam int N  = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]         cl_req, cl_we;
  logic [N-1:0][AW-1:0] cl_addr;
  logic [N-1:0][15:0]   cl_wdata;
  logic [N-1:0][1:0]    cl_be;
  logic [N-1:0]         cl_gnt, cl_rvalid;
  logic [15:0]          cl_rdata;
  logic [AW-1:0]        mem_wa, mem_ra;
  logic [15:0]          mem_wd, mem_rd;
  logic                 mem_we, mem_re;
  logic [1:0]           mem_be;

  sdpram16_arbiter #(.NUM_CLIENTS(N), .ADDR_WIDTH(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cl_req_i          (cl_req),
    .cl_we_i           (cl_we),
    .cl_addr_i         (cl_addr),
    .cl_wdata_i        (cl_wdata),
    .cl_be_i           (cl_be),
    .cl_gnt_o          (cl_gnt),
    .cl_rvalid_o       (cl_rvalid),
    .cl_rdata_o        (cl_rdata),
    .mem_write_addr_o  (mem_wa),
    .mem_write_data_o  (mem_wd),
    .mem_write_enable_o(mem_we),
    .mem_byte_enable_o (mem_be),
    .mem_read_addr_o   (mem_ra),
    .mem_read_enable_o (mem_re),
    .mem_read_data_i   (mem_rd)
  );

  // Behavioural sdpram16: read sampled on the enable cycle, data two cycles on.
  logic [15:0] ram [1024];
  logic [15:0] ram_s1, ram_s2;
  initial begin
    for (int a = 0; a < 1024; a++) ram[a] = 16'h0000;
    ram_s1 = 16'h0000;
    ram_s2 = 16'h0000;
  end
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_be[0]) ram[mem_wa][7:0]  <= mem_wd[7:0];
      if (mem_be[1]) ram[mem_wa][15:8] <= mem_wd[15:8];
    end
    if (mem_re) ram_s1 <= ram[mem_ra];
    ram_s2 <= ram_s1;
  end
  assign mem_rd = ram_s2;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // The RAM must never see both enables in one cycle.
  always @(negedge clk) check("mem_en_exclusive", {31'b0, mem_we & mem_re}, 32'd0);

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // One client (c) or none (c = -1) requests per vector; outputs are what the
  // registered ports should show during that same cycle.
  typedef struct {
    int          c;
    logic        we;
    logic [9:0]  addr;
    logic [15:0] wd;
    logic [1:0]  be;
    logic [3:0]  gnt;
    logic        mwe;
    logic        mre;
    logic [9:0]  mwa;
    logic [15:0] mwd;
    logic [1:0]  mbe;
    logic [9:0]  mra;
    logic [3:0]  rv;
    logic [15:0] rd;
  } vec_t;

  vec_t vt [10];

  task automatic drive(input logic [3:0] req, input logic [3:0] we,
                       input logic [9:0] addr, input logic [15:0] wd, input logic [1:0] be);
    cl_req = req;
    cl_we  = we;
    for (int i = 0; i < N; i++) begin
      cl_addr[i]  = addr;
      cl_wdata[i] = wd;
      cl_be[i]    = be;
    end
  endtask

  // Per-client read addresses and the data the RAM holds there by then.
  logic [9:0]  caddr [4];
  logic [15:0] cdata [4];
  int          exp_id [11];
  logic [3:0]  seq_req [11];

  initial begin
    // ---- tests 1, 2, 4: single write/read, byte enables, read-after-write
    //          c  we    addr     wd        be     gnt     mwe   mre   mwa      mwd       mbe    mra      rv      rd
    vt[0] = '{1, 1'b1, 10'h005, 16'hBEEF, 2'b11, 4'b0010, 1'b0, 1'b0, 10'h000, 16'h0000, 2'b00, 10'h000, 4'b0000, 16'h0000};
    vt[1] = '{1, 1'b0, 10'h005, 16'h0000, 2'b00, 4'b0010, 1'b1, 1'b0, 10'h005, 16'hBEEF, 2'b11, 10'h000, 4'b0000, 16'h0000};
    vt[2] = '{2, 1'b1, 10'h010, 16'h1234, 2'b11, 4'b0100, 1'b0, 1'b1, 10'h005, 16'hBEEF, 2'b11, 10'h005, 4'b0000, 16'h0000};
    vt[3] = '{3, 1'b1, 10'h010, 16'hAB00, 2'b10, 4'b1000, 1'b1, 1'b0, 10'h010, 16'h1234, 2'b11, 10'h005, 4'b0000, 16'h0000};
    vt[4] = '{0, 1'b0, 10'h010, 16'h0000, 2'b00, 4'b0001, 1'b1, 1'b0, 10'h010, 16'hAB00, 2'b10, 10'h005, 4'b0010, 16'hBEEF};
    vt[5] = '{2, 1'b1, 10'h3FF, 16'h5555, 2'b11, 4'b0100, 1'b0, 1'b1, 10'h010, 16'hAB00, 2'b10, 10'h010, 4'b0000, 16'h0000};
    vt[6] = '{3, 1'b0, 10'h3FF, 16'h0000, 2'b00, 4'b1000, 1'b1, 1'b0, 10'h3FF, 16'h5555, 2'b11, 10'h010, 4'b0000, 16'h0000};
    vt[7] = '{-1, 1'b0, 10'h000, 16'h0000, 2'b00, 4'b0000, 1'b0, 1'b1, 10'h3FF, 16'h5555, 2'b11, 10'h3FF, 4'b0001, 16'hAB34};
    vt[8] = '{-1, 1'b0, 10'h000, 16'h0000, 2'b00, 4'b0000, 1'b0, 1'b0, 10'h3FF, 16'h5555, 2'b11, 10'h3FF, 4'b0000, 16'h0000};
    vt[9] = '{-1, 1'b0, 10'h000, 16'h0000, 2'b00, 4'b0000, 1'b0, 1'b0, 10'h3FF, 16'h5555, 2'b11, 10'h3FF, 4'b1000, 16'h5555};

    caddr[0] = 10'h005; cdata[0] = 16'hBEEF;
    caddr[1] = 10'h010; cdata[1] = 16'hAB34;
    caddr[2] = 10'h3FF; cdata[2] = 16'h5555;
    caddr[3] = 10'h005; cdata[3] = 16'hBEEF;

    for (int k = 0; k < 11; k++) begin
`ifdef SDPRAM16_ARB_FIXED_PRIO_EN
      seq_req[k] = (k < 3) ? 4'b0111 : (k < 8) ? 4'b0110 : 4'b0000;
`else
      seq_req[k] = (k < 8) ? 4'b1111 : 4'b0000;
      exp_id[k]  = (k < 8) ? (k % 4) : -1;
`endif
    end
`ifdef SDPRAM16_ARB_FIXED_PRIO_EN
    exp_id = '{0, 0, 0, 1, 2, 1, 2, 1, -1, -1, -1};
`endif

    // ---- reset state, with every client requesting
    rst_n = 1'b1;
    drive(4'b1111, 4'b0000, 10'h155, 16'hFFFF, 2'b11);
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #4;
    check("rst_gnt",    {28'b0, cl_gnt},    32'd0);
    check("rst_we",     {31'b0, mem_we},    32'd0);
    check("rst_re",     {31'b0, mem_re},    32'd0);
    check("rst_wa",     {22'b0, mem_wa},    32'd0);
    check("rst_wd",     {16'b0, mem_wd},    32'd0);
    check("rst_be",     {30'b0, mem_be},    32'd0);
    check("rst_ra",     {22'b0, mem_ra},    32'd0);
    check("rst_rvalid", {28'b0, cl_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 10'h000, 16'h0000, 2'b00);

    // ---- table-driven vectors
    for (int v = 0; v < 10; v++) begin
      @(posedge clk); #1;
      drive((vt[v].c >= 0) ? (4'b0001 << vt[v].c) : 4'b0000,
            (vt[v].c >= 0 && vt[v].we) ? (4'b0001 << vt[v].c) : 4'b0000,
            vt[v].addr, vt[v].wd, vt[v].be);
      #3;
      check($sformatf("v%0d_gnt", v), {28'b0, cl_gnt},    {28'b0, vt[v].gnt});
      check($sformatf("v%0d_mwe", v), {31'b0, mem_we},    {31'b0, vt[v].mwe});
      check($sformatf("v%0d_mre", v), {31'b0, mem_re},    {31'b0, vt[v].mre});
      check($sformatf("v%0d_mwa", v), {22'b0, mem_wa},    {22'b0, vt[v].mwa});
      check($sformatf("v%0d_mwd", v), {16'b0, mem_wd},    {16'b0, vt[v].mwd});
      check($sformatf("v%0d_mbe", v), {30'b0, mem_be},    {30'b0, vt[v].mbe});
      check($sformatf("v%0d_mra", v), {22'b0, mem_ra},    {22'b0, vt[v].mra});
      check($sformatf("v%0d_rv",  v), {28'b0, cl_rvalid}, {28'b0, vt[v].rv});
      if (vt[v].rv != 4'b0000)
        check($sformatf("v%0d_rd", v), {16'b0, cl_rdata}, {16'b0, vt[v].rd});
    end

    // ---- full load (round-robin, or fixed-priority client 0), from reset
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 10'h000, 16'h0000, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      @(posedge clk); #1;
      cl_req = seq_req[k];
      cl_we  = 4'b0000;
      for (int i = 0; i < N; i++) cl_addr[i] = caddr[i];
      #3;
      check($sformatf("load%0d_gnt", k), {28'b0, cl_gnt},
            (exp_id[k] >= 0) ? (32'd1 << exp_id[k]) : 32'd0);
      check($sformatf("load%0d_mwe", k), {31'b0, mem_we}, 32'd0);
      check($sformatf("load%0d_mre", k), {31'b0, mem_re},
            (k >= 1 && exp_id[k-1] >= 0) ? 32'd1 : 32'd0);
      if (k >= 1 && exp_id[k-1] >= 0)
        check($sformatf("load%0d_mra", k), {22'b0, mem_ra}, {22'b0, caddr[exp_id[k-1]]});
      if (k >= 3 && exp_id[k-3] >= 0) begin
        check($sformatf("load%0d_rv", k), {28'b0, cl_rvalid}, 32'd1 << exp_id[k-3]);
        check($sformatf("load%0d_rd", k), {16'b0, cl_rdata}, {16'b0, cdata[exp_id[k-3]]});
      end else begin
        check($sformatf("load%0d_rv", k), {28'b0, cl_rvalid}, 32'd0);
      end
    end

    // ---- reset mid-flight: reads from c0 then c1, then one reset cycle
    @(posedge clk); #1;
    cl_req = 4'b0001;
    #3 check("mid_gnt_c0", {28'b0, cl_gnt}, 32'h1);
    @(posedge clk); #1;
    cl_req = 4'b0010;
    #3 check("mid_gnt_c1", {28'b0, cl_gnt}, 32'h2);
    @(posedge clk); #1;
    rst_n  = 1'b0;
    cl_req = 4'b1111;
    #3;
    check("mid_rst_gnt",    {28'b0, cl_gnt},    32'd0);
    check("mid_rst_we",     {31'b0, mem_we},    32'd0);
    check("mid_rst_re",     {31'b0, mem_re},    32'd0);
    check("mid_rst_ra",     {22'b0, mem_ra},    32'd0);
    check("mid_rst_wa",     {22'b0, mem_wa},    32'd0);
    check("mid_rst_rvalid", {28'b0, cl_rvalid}, 32'd0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    cl_req = 4'b1110;
    #3;
    check("post_rst_gnt_ptr0", {28'b0, cl_gnt},    32'h2);
    check("post_rst_rv0",      {28'b0, cl_rvalid}, 32'd0);
    check("post_rst_re",       {31'b0, mem_re},    32'd0);
    @(posedge clk); #1;
    cl_req = 4'b0000;
    #3;
    check("post_rst_rv1", {28'b0, cl_rvalid}, 32'd0);
    check("post_rst_re1", {31'b0, mem_re},    32'd1);
    check("post_rst_ra1", {22'b0, mem_ra},    32'h010);
    @(posedge clk); #4;
    check("post_rst_rv2", {28'b0, cl_rvalid}, 32'd0);
    @(posedge clk); #4;
    check("post_rst_rv3", {28'b0, cl_rvalid}, 32'h2);
    check("post_rst_rd3", {16'b0, cl_rdata},  32'hAB34);
    @(posedge clk); #4;
    check("post_rst_rv4", {28'b0, cl_rvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
